// File: rtl/seq_cla_subtractor_pkg.sv
// Shared definitions for the nibble-serial CLA subtractor and its adder-side siblings.
// Holds the FSM state type, the slice width and the signed overflow rule.
package seq_cla_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int SLICE_W = 4;

  // Two's-complement overflow of x + y = r, from sign bits only; a subtractor passes ~b's MSB as y.
  function automatic logic add_overflow(input logic x_msb, input logic y_msb, input logic r_msb);
    return (x_msb == y_msb) && (r_msb != x_msb);
  endfunction

endpackage

// File: rtl/seq_cla_subtractor_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice; all carries expanded from G/P and c0.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g = x & y;
  assign p = x ^ y;

  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);

  assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/seq_cla_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one nibble per clock through a
// single CLA slice as a + ~b + carry, with the inter-nibble carry held in a register.
module seq_cla_subtractor
  import seq_cla_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("seq_cla_subtractor: WIDTH must be a positive multiple of 4");
  end

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic             bout_q;
  logic             ovf_q;
  logic             last_nib;
  logic [3:0]       x_nib;
  logic [3:0]       y_nib;
  logic [3:0]       s_nib;
  logic             c4;

  assign last_nib = (idx == LAST_IDX);
  assign x_nib    = a_q[idx*SLICE_W +: SLICE_W];
  assign y_nib    = ~b_q[idx*SLICE_W +: SLICE_W];

  cla4_slice u_slice (
    .x  (x_nib),
    .y  (y_nib),
    .c0 (carry_q),
    .s  (s_nib),
    .c4 (c4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and nibble-serial datapath; results persist until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ~bin;
            idx     <= '0;
          end
        end
        RUN: begin
          diff_q[idx*SLICE_W +: SLICE_W] <= s_nib;
          carry_q <= c4;
          idx     <= idx + 1'b1;
          if (last_nib) begin
            bout_q <= ~c4;
            ovf_q  <= add_overflow(a_q[WIDTH-1], ~b_q[WIDTH-1], s_nib[3]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Directed scoreboard bench for seq_cla_subtractor at WIDTH=16.
module tb_seq_cla_subtractor;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  res_t sb[$];
  int   ncomp = 0;
  int   nfail = 0;
  int   ndone = 0;
  int   nexp  = 0;

  always #5 clk = ~clk;

  seq_cla_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] t;
    res_t       r;
    t    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    r.d  = t[W-1:0];
    r.bo = t[W];
    r.ov = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    res_t e;
    if (done === 1'b1) begin
      ndone++;
      if (sb.size() == 0) begin
        ncomp++;
        nfail++;
        $error("FAIL unexpected_done: observed done=1 with diff 0x%0h expected no result", diff);
      end else begin
        e = sb.pop_front();
        check("diff", diff, e.d);
        check1("bout", bout, e.bo);
        check1("overflow", overflow, e.ov);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1("idle_timeout", busy, 1'b0);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    res_t e;
    wait_idle();
    a     = x;
    b     = y;
    bin   = bi;
    start = 1'b1;
    e     = model(x, y, bi);
    sb.push_back(e);
    nexp++;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    bin   = 1'($urandom);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check1("busy_latency", busy, (k <= 4));
      check1("done_latency", done, (k == 4));
      if (k == 5) check("hold_diff", diff, e.d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check("rst_diff", diff, 16'h0000);
    check1("rst_bout", bout, 1'b0);
    check1("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h0034, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1);
    run_op(16'h0005, 16'h0005, 1'b0);

    // Start held high with operands changing through RUN and DONE.
    wait_idle();
    a     = 16'h00F0;
    b     = 16'h000F;
    bin   = 1'b0;
    start = 1'b1;
    sb.push_back(model(16'h00F0, 16'h000F, 1'b0));
    nexp++;
    @(posedge clk);
    #1;
    a = 16'hAAAA;
    b = 16'h5555;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check1("held_busy", busy, (k <= 4));
      check1("held_done", done, (k == 4));
    end
    sb.push_back(model(16'hAAAA, 16'h5555, 1'b0));
    nexp++;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check1("second_done", done, (k == 4));
    end

    // Reset in the second RUN cycle aborts the operation.
    wait_idle();
    a     = 16'h1235;
    b     = 16'h0001;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check("abort_diff", diff, 16'h0000);
    check1("abort_bout", bout, 1'b0);
    check1("abort_ovf", overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check1("abort_no_done", done, 1'b0);
    end
    run_op(16'h0100, 16'h0001, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", W'(sb.size()), 16'd0);
    check("done_count", W'(ndone), W'(nexp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/seq_cla_subtractor.md
Name: seq_cla_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor. Computes diff = a - b - bin.
- Processes one 4-bit nibble per clock through a single 4-bit carry-lookahead slice, using the identity a + ~b + carry.
- The carry between nibbles is registered from one cycle to the next.
- Serves as the subtract/compare companion to the existing 4-bit CLA adder, for datapaths that trade latency for area.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4; elaboration fails otherwise.
- NSLICE, WIDTH/4, derived localparam: number of nibble cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe. Sampled only in IDLE.
- a  input  WIDTH  minuend. Captured when start is accepted.
- b  input  WIDTH  subtrahend. Captured when start is accepted.
- bin  input  1  borrow-in. Captured when start is accepted.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  difference.
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, diff=0, bout=0, overflow=0.
  - Operand registers, nibble index and carry register cleared.
  - Reset during RUN aborts the operation: no done pulse, and no partial result remains visible.
- FSM states IDLE, RUN, DONE:
  - IDLE: on a clock edge with start=1, capture a, b, bin. Set carry register = ~bin, index=0, go to RUN. start=0 keeps IDLE.
  - RUN: each edge feeds nibble[index] of a, ~b nibble[index] and the carry register into the CLA slice.
    - Slice sum is written to diff nibble[index].
    - Slice carry-out is stored to the carry register.
    - index increments.
    - On the edge that processes index=NSLICE-1:
      - bout = ~carry_out.
      - overflow = (a[MSB] != b[MSB]) && (new diff[MSB] != a[MSB]).
      - Go to DONE.
  - DONE: done=1 for exactly this cycle, then unconditionally go to IDLE.
- Latency: acceptance at edge E0; done is high in the cycle after edge E0+NSLICE.
  - Minimum start-to-start spacing is NSLICE+2 cycles.
- start while busy=1 (RUN or DONE) is ignored. Captured operands are unaffected by input changes after acceptance.
- diff, bout and overflow:
  - Hold their values from DONE through IDLE until the next accepted start.
  - During RUN, diff nibbles update progressively. Consumers must qualify results with done only.
- Wrap-around: the result is modulo 2^WIDTH.
  - Example: 0 - 1 gives diff all ones and bout=1.
- bin=1 with a == b gives diff all ones and bout=1.
- All arithmetic is unsigned at the slice level. Only the overflow flag is signed.

Decomposition:
- Shared package:
  - State enum {IDLE, RUN, DONE}.
  - Constant SLICE_W=4.
  - Function for the signed overflow rule, reusable by an adder-side wrapper.
- One sub-module, cla4_slice: combinational 4-bit carry-lookahead.
  - Inputs: x[3:0], y[3:0], c0.
  - Outputs: s[3:0], c4.
  - Implements generate/propagate G=x&y, P=x^y, with carries expanded in lookahead form (no ripple).
  - Instantiated once; the top does the inversion of b.

Test Plan (WIDTH=16, NSLICE=4):
- a=0x1234, b=0x0034, bin=0, start pulse -> done exactly 5 cycles after the start edge (E0+4 edge). diff=0x1200, bout=0, overflow=0. busy high for 5 cycles.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, overflow=0.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, overflow=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, overflow=1.
- a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1, overflow=0. Same operands with bin=0 -> diff=0x0000, bout=0.
- Accept a=0x00F0, b=0x000F. Hold start=1 and change operands to 0xAAAA/0x5555 through RUN and DONE -> first result diff=0x00E1 reported once. Second operation accepted only after return to IDLE, giving diff=0x5555.
- Assert rst for 1 cycle during the second RUN cycle -> all outputs 0 immediately (asynchronous), no done pulse. A following start with a=0x0100, b=0x0001 gives diff=0x00FF, bout=0 with normal latency.
